// File: rtl/lift_pkg.sv
// Shared constants and types for the lift request panel.
package lift_pkg;
    localparam int   N_FLOORS_DEFAULT = 12;
    localparam int   DEBOUNCE_DEFAULT = 4;
    localparam logic DIR_UP           = 1'b1;
    localparam logic DIR_DN           = 1'b0;

    typedef logic [N_FLOORS_DEFAULT-1:0] floor_vec_t;
endpackage

// File: rtl/lift_btn_debounce.sv
// One button: 2-flop synchronizer, saturating debounce counter, single-cycle press pulse.
// Pulse fires in the cycle the counter steps onto DEBOUNCE_CYCLES, so the consumer latches on that edge.
module lift_btn_debounce
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

    logic [1:0] sync_q, sync_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        cnt_d   = cnt_q;
        if (!sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Only the step from MAX-1 to MAX pulses; the counter then sits at MAX until release.
        press_o = sync_q[1] && (cnt_q == CNT_MAX - 8'd1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/lift_request_panel.sv
// Hall/car call panel: debounces buttons, latches requests, clears them when the car serves a floor.
// Multi-hot floor_sense blocks all clears and raises a sticky error until reset.
module lift_request_panel
    import lift_pkg::*;
#(
    parameter int N_FLOORS        = N_FLOORS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] up_btn,
    input  logic [N_FLOORS-1:0] dn_btn,
    input  logic [N_FLOORS-1:0] car_btn,
    input  logic [N_FLOORS-1:0] floor_sense,
    input  logic                direction,
    input  logic                motion,
    input  logic                door_open,
    output logic [N_FLOORS-1:0] up_rqst,
    output logic [N_FLOORS-1:0] dn_rqst,
    output logic [N_FLOORS-1:0] flr_rqst,
    output logic                any_rqst,
    output logic                sense_err
);

    localparam logic [N_FLOORS-1:0] ONE_V   = {{(N_FLOORS-1){1'b0}}, 1'b1};
    // No up call exists at the top floor, nor a down call at the bottom.
    localparam logic [N_FLOORS-1:0] UP_MASK = ~(ONE_V << (N_FLOORS-1));
    localparam logic [N_FLOORS-1:0] DN_MASK = ~ONE_V;

    logic [N_FLOORS-1:0] up_evt, dn_evt, flr_evt;
    logic [N_FLOORS-1:0] up_q, up_d, dn_q, dn_d, flr_q, flr_d;
    logic                any_q, any_d, err_q, err_d;
    logic [N_FLOORS-1:0] served, up_clr, dn_clr, others;
    logic                fs_multi, fs_onehot, no_other;

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_floor
        lift_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
            .clk_i(clk), .rst_i(reset), .btn_i(up_btn[i]),  .press_o(up_evt[i])
        );
        lift_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
            .clk_i(clk), .rst_i(reset), .btn_i(dn_btn[i]),  .press_o(dn_evt[i])
        );
        lift_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
            .clk_i(clk), .rst_i(reset), .btn_i(car_btn[i]), .press_o(flr_evt[i])
        );
    end

    always_comb begin
        fs_multi  = |(floor_sense & (floor_sense - ONE_V));
        fs_onehot = (|floor_sense) & ~fs_multi;
        served    = (door_open && !motion && fs_onehot) ? floor_sense : '0;
        // With nothing pending elsewhere, the car may leave either way, so both hall calls go.
        others    = (up_q | dn_q | flr_q) & ~served;
        no_other  = ~|others;
        up_clr    = (direction == DIR_UP || no_other) ? served : '0;
        dn_clr    = (direction == DIR_DN || no_other) ? served : '0;

        up_d  = (up_q  | (up_evt & UP_MASK)) & ~up_clr & UP_MASK;
        dn_d  = (dn_q  | (dn_evt & DN_MASK)) & ~dn_clr & DN_MASK;
        flr_d = (flr_q | flr_evt) & ~served;
        any_d = |{up_q, dn_q, flr_q};
        err_d = err_q | fs_multi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_q  <= '0;
            dn_q  <= '0;
            flr_q <= '0;
            any_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            up_q  <= up_d;
            dn_q  <= dn_d;
            flr_q <= flr_d;
            any_q <= any_d;
            err_q <= err_d;
        end
    end

    assign up_rqst   = up_q;
    assign dn_rqst   = dn_q;
    assign flr_rqst  = flr_q;
    assign any_rqst  = any_q;
    assign sense_err = err_q;

endmodule

// File: tb/tb_lift_request_panel.sv
// Directed bench for lift_request_panel at default parameters (12 floors, debounce 4).
module tb_lift_request_panel;
    import lift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    floor_vec_t up_btn, dn_btn, car_btn, floor_sense;
    logic       direction, motion, door_open;
    floor_vec_t up_rqst, dn_rqst, flr_rqst;
    logic       any_rqst, sense_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lift_request_panel dut (
        .clk(clk), .reset(reset),
        .up_btn(up_btn), .dn_btn(dn_btn), .car_btn(car_btn),
        .floor_sense(floor_sense), .direction(direction),
        .motion(motion), .door_open(door_open),
        .up_rqst(up_rqst), .dn_rqst(dn_rqst), .flr_rqst(flr_rqst),
        .any_rqst(any_rqst), .sense_err(sense_err)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        up_btn = '0; dn_btn = '0; car_btn = '0; floor_sense = '0;
        direction = 1'b0; motion = 1'b0; door_open = 1'b0;
    endtask

    task automatic serve(input int fl, input logic dir);
        floor_sense = '0; floor_sense[fl] = 1'b1;
        door_open = 1'b1; motion = 1'b0; direction = dir;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(3);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL reset_up: got %h want 000", up_rqst); end
        n_cmp++; if (dn_rqst !== 12'h000) begin n_err++; $display("FAIL reset_dn: got %h want 000", dn_rqst); end
        n_cmp++; if (flr_rqst !== 12'h000) begin n_err++; $display("FAIL reset_flr: got %h want 000", flr_rqst); end
        n_cmp++; if (any_rqst !== 1'b0) begin n_err++; $display("FAIL reset_any: got %b want 0", any_rqst); end
        n_cmp++; if (sense_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", sense_err); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_debounce_hold();
        logic exp;
        car_btn[6] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            exp = (t >= 6);
            n_cmp++; if (flr_rqst[6] !== exp) begin n_err++; $display("FAIL hold_flr6 edge %0d: got %b want %b", t, flr_rqst[6], exp); end
            exp = (t >= 7);
            n_cmp++; if (any_rqst !== exp) begin n_err++; $display("FAIL hold_any edge %0d: got %b want %b", t, any_rqst, exp); end
        end
        serve(6, DIR_UP);
        tick(1);
        n_cmp++; if (flr_rqst !== 12'h000) begin n_err++; $display("FAIL hold_served: got %h want 000", flr_rqst); end
        floor_sense = '0; door_open = 1'b0;
        tick(8);
        n_cmp++; if (flr_rqst !== 12'h000) begin n_err++; $display("FAIL hold_no_repeat: got %h want 000", flr_rqst); end
        idle_inputs();
        tick(3);
    endtask

    task automatic test_glitch();
        up_btn[3] = 1'b1; tick(2); up_btn[3] = 1'b0; tick(10);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL glitch_2cyc: got %h want 000", up_rqst); end
        up_btn[3] = 1'b1; tick(3); up_btn[3] = 1'b0; tick(10);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL glitch_3cyc: got %h want 000", up_rqst); end
        up_btn[3] = 1'b1; tick(4); up_btn[3] = 1'b0; tick(10);
        n_cmp++; if (up_rqst !== 12'h008) begin n_err++; $display("FAIL glitch_4cyc: got %h want 008", up_rqst); end
        reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    endtask

    task automatic test_boundary();
        up_btn[11] = 1'b1; dn_btn[0] = 1'b1;
        tick(10);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL bound_up: got %h want 000", up_rqst); end
        n_cmp++; if (dn_rqst !== 12'h000) begin n_err++; $display("FAIL bound_dn: got %h want 000", dn_rqst); end
        n_cmp++; if (any_rqst !== 1'b0) begin n_err++; $display("FAIL bound_any: got %b want 0", any_rqst); end
        idle_inputs();
        tick(3);
    endtask

    task automatic test_serve();
        up_btn[3] = 1'b1; dn_btn[3] = 1'b1; car_btn[8] = 1'b1;
        tick(6);
        idle_inputs();
        tick(4);
        n_cmp++; if (up_rqst !== 12'h008) begin n_err++; $display("FAIL serve_setup_up: got %h want 008", up_rqst); end
        n_cmp++; if (dn_rqst !== 12'h008) begin n_err++; $display("FAIL serve_setup_dn: got %h want 008", dn_rqst); end
        n_cmp++; if (flr_rqst !== 12'h100) begin n_err++; $display("FAIL serve_setup_flr: got %h want 100", flr_rqst); end
        serve(3, DIR_UP); motion = 1'b1;
        tick(1);
        n_cmp++; if (up_rqst !== 12'h008) begin n_err++; $display("FAIL serve_moving: got %h want 008", up_rqst); end
        floor_sense = '0; motion = 1'b0;
        tick(1);
        n_cmp++; if (up_rqst !== 12'h008) begin n_err++; $display("FAIL serve_between: got %h want 008", up_rqst); end
        serve(3, DIR_UP);
        tick(1);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL serve_up_clr: got %h want 000", up_rqst); end
        n_cmp++; if (dn_rqst !== 12'h008) begin n_err++; $display("FAIL serve_dn_kept: got %h want 008", dn_rqst); end
        n_cmp++; if (flr_rqst !== 12'h100) begin n_err++; $display("FAIL serve_flr_kept: got %h want 100", flr_rqst); end
        serve(3, DIR_DN);
        tick(1);
        n_cmp++; if (dn_rqst !== 12'h000) begin n_err++; $display("FAIL serve_dn_clr: got %h want 000", dn_rqst); end
        serve(8, DIR_DN);
        tick(1);
        n_cmp++; if (flr_rqst !== 12'h000) begin n_err++; $display("FAIL serve_flr_clr: got %h want 000", flr_rqst); end
        idle_inputs();
        up_btn[5] = 1'b1; dn_btn[5] = 1'b1;
        tick(6);
        idle_inputs();
        tick(2);
        serve(5, DIR_UP);
        tick(1);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL serve_alone_up: got %h want 000", up_rqst); end
        n_cmp++; if (dn_rqst !== 12'h000) begin n_err++; $display("FAIL serve_alone_dn: got %h want 000", dn_rqst); end
        idle_inputs();
        tick(3);
    endtask

    task automatic test_collision();
        car_btn[7] = 1'b1; tick(6); car_btn[7] = 1'b0; tick(3);
        n_cmp++; if (flr_rqst !== 12'h080) begin n_err++; $display("FAIL coll_setup: got %h want 080", flr_rqst); end
        car_btn[2] = 1'b1; up_btn[7] = 1'b1;
        tick(5);
        serve(7, DIR_UP);
        tick(1);
        n_cmp++; if (flr_rqst !== 12'h004) begin n_err++; $display("FAIL coll_flr: got %h want 004", flr_rqst); end
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL coll_same_bit: got %h want 000", up_rqst); end
        floor_sense = '0; door_open = 1'b0;
        tick(5);
        n_cmp++; if (up_rqst !== 12'h000) begin n_err++; $display("FAIL coll_held_rearm: got %h want 000", up_rqst); end
        idle_inputs();
        tick(3);
    endtask

    task automatic test_sense_err();
        reset = 1'b1; tick(1); reset = 1'b0;
        car_btn[4] = 1'b1; car_btn[5] = 1'b1;
        tick(6);
        idle_inputs();
        tick(2);
        n_cmp++; if (sense_err !== 1'b0) begin n_err++; $display("FAIL err_pre: got %b want 0", sense_err); end
        floor_sense = 12'h030; door_open = 1'b1;
        tick(1);
        n_cmp++; if (sense_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", sense_err); end
        n_cmp++; if (flr_rqst !== 12'h030) begin n_err++; $display("FAIL err_no_clr: got %h want 030", flr_rqst); end
        idle_inputs();
        tick(5);
        n_cmp++; if (sense_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", sense_err); end
        reset = 1'b1; tick(1); reset = 1'b0;
        n_cmp++; if (sense_err !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b want 0", sense_err); end
        tick(2);
    endtask

    task automatic test_reset_mid();
        logic exp;
        car_btn[2] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_cmp++; if (flr_rqst !== 12'h000) begin n_err++; $display("FAIL rstmid_cleared: got %h want 000", flr_rqst); end
        for (int t = 1; t <= 8; t++) begin
            tick(1);
            exp = (t >= 6);
            n_cmp++; if (flr_rqst[2] !== exp) begin n_err++; $display("FAIL rstmid_flr2 edge %0d: got %b want %b", t, flr_rqst[2], exp); end
        end
        idle_inputs();
        tick(2);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_debounce_hold();
        test_glitch();
        test_boundary();
        test_serve();
        test_collision();
        test_sense_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
